demux_1_5_btn: RTL and testbench



---
 rtl/demux_1_5_btn.sv | 124 ++++++++++++
 tb/tb_demux_1_5_btn.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/demux_1_5_btn.sv
// rtl/demux_1_5_btn.sv - registered 1-to-5 demux stepped and committed by debounced push-buttons

module demux_1_5_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_1  <= raw;
      sync_2  <= sync_1;
      level_q <= level;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

module demux_1_5_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       my_in,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  input  logic       btn_d,
  output logic [2:0] sel,
  output logic [4:0] my_out,
  output logic       wr_strobe
);
  logic       in_sync_1;
  logic       in_sync_2;
  logic       press_l;
  logic       press_r;
  logic       press_c;
  logic       press_d;
  logic [2:0] sel_next;
  logic [4:0] out_next;

  demux_1_5_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_l (
    .clk(clk), .rst(rst), .raw(btn_l), .press(press_l)
  );
  demux_1_5_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_r (
    .clk(clk), .rst(rst), .raw(btn_r), .press(press_r)
  );
  demux_1_5_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_c (
    .clk(clk), .rst(rst), .raw(btn_c), .press(press_c)
  );
  demux_1_5_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_d (
    .clk(clk), .rst(rst), .raw(btn_d), .press(press_d)
  );

  // Opposing L/R presses in one cycle cancel out.
  always_comb begin
    sel_next = sel;
    if (press_r && !press_l) begin
      sel_next = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
    end else if (press_l && !press_r) begin
      sel_next = (sel == 3'd0) ? 3'd4 : sel - 3'd1;
    end
  end

  // Commit uses the pre-update sel; clear wins over a same-cycle commit.
  always_comb begin
    out_next = my_out;
    if (press_d) begin
      out_next = '0;
    end else if (press_c) begin
      for (int k = 0; k < 5; k++) begin
        if (sel == 3'(k)) begin
          out_next[k] = in_sync_2;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_sync_1 <= 1'b0;
      in_sync_2 <= 1'b0;
      sel       <= 3'd0;
      my_out    <= '0;
      wr_strobe <= 1'b0;
    end else begin
      in_sync_1 <= my_in;
      in_sync_2 <= in_sync_1;
      sel       <= sel_next;
      my_out    <= out_next;
      wr_strobe <= press_c | press_d;
    end
  end

endmodule

// File: tb/tb_demux_1_5_btn.sv
// tb/tb_demux_1_5_btn.sv - self-checking bench for demux_1_5_btn

module tb_demux_1_5_btn;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       my_in = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_r = 1'b0;
  logic       btn_c = 1'b0;
  logic       btn_d = 1'b0;
  logic [2:0] sel;
  logic [4:0] my_out;
  logic       wr_strobe;

  int         tests = 0;
  int         fails = 0;
  int         strobes = 0;
  int         ref_sel = 0;
  logic [4:0] ref_out = '0;
  int         ref_strobes = 0;

  demux_1_5_btn #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .my_in(my_in),
    .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c), .btn_d(btn_d),
    .sel(sel), .my_out(my_out), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  // Every cycle the strobe is high counts, so a stretched pulse shows up as an extra strobe.
  always @(negedge clk) if (wr_strobe === 1'b1) strobes++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_apply(input bit l, input bit r, input bit c, input bit d, input logic v);
    if (d) ref_out = '0;
    else if (c) ref_out[ref_sel] = v;
    if (c || d) ref_strobes++;
    if (r && !l) ref_sel = (ref_sel + 1) % 5;
    else if (l && !r) ref_sel = (ref_sel + 4) % 5;
  endfunction

  task automatic press(input bit l, input bit r, input bit c, input bit d, input int hold);
    @(negedge clk);
    btn_l = l; btn_r = r; btn_c = c; btn_d = d;
    cycles(hold);
    btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0; btn_d = 1'b0;
    cycles(12);
    model_apply(l, r, c, d, my_in);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".sel"}, 32'(sel), ref_sel);
    check({tag, ".my_out"}, 32'(my_out), 32'(ref_out));
    check({tag, ".strobes"}, strobes, ref_strobes);
  endtask

  initial begin
    int n;
    int op;
    cycles(3);
    rst = 1'b0;
    check("reset.sel", 32'(sel), 0);
    check("reset.my_out", 32'(my_out), 0);
    check("reset.wr_strobe", 32'(wr_strobe), 0);
    cycles(20);
    check("idle.strobes", strobes, 0);

    // First R press also measures raw-edge to sel-update latency.
    my_in = 1'b1;
    @(negedge clk);
    btn_r = 1'b1;
    n = 0;
    while (sel === 3'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("r_latency_in_window", 32'(n >= 5 && n <= 8), 1);
    cycles(4);
    btn_r = 1'b0;
    cycles(12);
    model_apply(0, 1, 0, 0, my_in);
    press(0, 1, 0, 0, 10);
    check_state("two_r");
    press(0, 0, 1, 0, 10);
    check_state("commit_sel2");

    @(negedge clk);
    btn_c = 1'b1;
    cycles(DC - 1);
    btn_c = 1'b0;
    cycles(12);
    check_state("glitch_c");

    press(1, 0, 0, 0, 10);
    press(1, 0, 0, 0, 10);
    press(1, 0, 0, 0, 10);
    check_state("wrap_l");
    press(0, 1, 0, 0, 10);
    check_state("wrap_r");
    press(0, 1, 0, 0, 100);
    check_state("hold_r");
    press(1, 1, 0, 0, 10);
    check_state("lr_same");
    my_in = 1'b1;
    press(0, 1, 1, 0, 10);
    check_state("cr_same");

    press(0, 1, 0, 0, 10);
    press(0, 1, 0, 0, 10);
    press(0, 0, 1, 0, 10);
    check_state("build_10110");
    press(0, 1, 0, 0, 10);
    press(0, 0, 1, 1, 10);
    check_state("cd_same");
    press(1, 0, 0, 0, 10);
    press(1, 0, 0, 0, 10);
    my_in = 1'b0;
    press(0, 0, 1, 0, 10);
    check_state("c_zero_sel3");

    for (int i = 0; i < 12; i++) begin
      my_in = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 6);
      case (op)
        0: press(1, 0, 0, 0, $urandom_range(8, 15));
        1: press(0, 1, 0, 0, $urandom_range(8, 15));
        2, 3: press(0, 0, 1, 0, $urandom_range(8, 15));
        4: press(0, 0, 0, 1, $urandom_range(8, 15));
        5: press(0, 1, 1, 0, $urandom_range(8, 15));
        default: press(1, 0, 1, 0, $urandom_range(8, 15));
      endcase
      check_state($sformatf("rand%0d", i));
    end

    my_in = 1'b1;
    if (ref_sel == 0) press(0, 1, 0, 0, 10);
    press(0, 0, 1, 0, 10);
    check_state("pre_reset");

    // Reset lands while btn_r's debounce counter sits at 2.
    @(negedge clk);
    btn_r = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst.sel", 32'(sel), 0);
    check("async_rst.my_out", 32'(my_out), 0);
    check("async_rst.wr_strobe", 32'(wr_strobe), 0);
    @(negedge clk);
    rst = 1'b0;
    ref_sel = 0;
    ref_out = '0;
    n = 0;
    while (sel === 3'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_held_r_latency", 32'(n >= 5 && n <= 8), 1);
    btn_r = 1'b0;
    cycles(12);
    ref_sel = 1;
    check_state("after_rst_r");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
